// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC + ReLU datapath: default operand width,
// product/accumulator width and the signed saturation bounds for a given width.
package mac_pkg;

  localparam int MAC_DATA_W = 32;

  // The product and the internal accumulator both carry twice the operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Largest positive value of a w-bit two's-complement number (w <= 128).
  function automatic logic [127:0] sat_max(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  // Most negative value of a w-bit two's-complement number, as a w-bit pattern.
  function automatic logic [127:0] sat_min(input int w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/relu_unit.sv
// Purely combinational ReLU: passes a non-negative two's-complement value through
// and forces negative values (MSB set) to zero.
module relu_unit
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
) (
  input  logic [DATA_W-1:0] mac_acc,
  output logic [DATA_W-1:0] relu_acc
);

  assign relu_acc = mac_acc[DATA_W-1] ? '0 : mac_acc;

endmodule

// File: rtl/mac_relu_unit.sv
// Two-stage signed multiply-accumulate with ReLU output. Build with MAC_SATURATE_EN
// defined to clamp acc to the DATA_W signed range; otherwise acc wraps.
module mac_relu_unit
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              enable,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] relu_acc,
  output logic              valid
);

  localparam int PROD_W = prod_w(DATA_W);

  // Handshake: enable=1 at an edge samples a/b; there is no backpressure. valid is high
  // for exactly the one cycle following each accumulator update, and clr (or reset)
  // drops any product still in flight so it never produces a valid pulse.

  logic [PROD_W-1:0] prod_full;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              pvld_q, pvld_d;
  logic [PROD_W-1:0] sum_q, sum_d;
  logic              vld_q, vld_d;

  // Sign-extending both operands makes the low PROD_W bits of an unsigned multiply
  // equal to the exact signed product.
  assign prod_full = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

  always_comb begin
    prod_d = prod_q;
    pvld_d = 1'b0;
    sum_d  = sum_q;
    vld_d  = 1'b0;
    if (clr) begin
      sum_d = '0;
    end else begin
      if (enable) begin
        prod_d = prod_full;
        pvld_d = 1'b1;
      end
      if (pvld_q) begin
        sum_d = sum_q + prod_q;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      pvld_q <= 1'b0;
      sum_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      pvld_q <= pvld_d;
      sum_q  <= sum_d;
      vld_q  <= vld_d;
    end
  end

`ifdef MAC_SATURATE_EN
  localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min(DATA_W));

  // The sum fits in DATA_W bits exactly when its top DATA_W+1 bits are all equal.
  logic [DATA_W:0] sum_top;
  assign sum_top = sum_q[PROD_W-1:DATA_W-1];

  always_comb begin
    acc = sum_q[DATA_W-1:0];
    if (!((&sum_top) || !(|sum_top))) begin
      acc = sum_q[PROD_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign acc = sum_q[DATA_W-1:0];
`endif

  assign valid = vld_q;

  relu_unit #(
    .DATA_W(DATA_W)
  ) u_relu (
    .mac_acc (acc),
    .relu_acc(relu_acc)
  );

endmodule

// File: tb/tb_mac_relu_unit.sv
// Self-checking bench for mac_relu_unit: constant vector tables, hand-written corner
// sequences and a randomized run against an arithmetic model of the accumulator.
module tb_mac_relu_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] acc;
  logic [W-1:0] relu_acc;
  logic         valid;

  int total = 0;
  int bad   = 0;

  mac_relu_unit #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .enable  (enable),
    .a       (a),
    .b       (b),
    .acc     (acc),
    .relu_acc(relu_acc),
    .valid   (valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Products accepted at one edge join the running sum at the following edge.
  logic [63:0] exp_q[$];
  bit          live_q[$];
  longint      m_sum = 0;
  bit          m_vld = 1'b0;

  function automatic logic [W-1:0] model_acc(input longint s);
`ifdef MAC_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] model_relu(input logic [W-1:0] v);
    return ($signed(v) < 0) ? '0 : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    live_q.delete();
    m_sum = 0;
    m_vld = 1'b0;
  endtask

  task automatic model_edge(input bit c, input bit e, input logic [W-1:0] va,
                            input logic [W-1:0] vb);
    longint p;
    if (c) begin
      model_reset();
    end else begin
      m_vld = 1'b0;
      if (exp_q.size() > 0) begin
        p = longint'(exp_q.pop_front());
        if (live_q.pop_front()) begin
          m_sum = m_sum + p;
          m_vld = 1'b1;
        end
      end
      p = longint'($signed(va)) * longint'($signed(vb));
      exp_q.push_back(64'(p));
      live_q.push_back(e);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, ".acc"}, acc, model_acc(m_sum));
    check({name, ".relu"}, relu_acc, model_relu(model_acc(m_sum)));
    check({name, ".valid"}, 32'(valid), 32'(m_vld));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit c, input bit e, input logic [W-1:0] va, input logic [W-1:0] vb);
    clr = c;
    enable = e;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    if (rst) model_edge(c, e, va, vb);
    else model_reset();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    bit           c;
    bit           e;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] acc;
    logic [W-1:0] relu;
    bit           vld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c, bit e, int va, int vb, int ea, int er, bit v);
    vec_t r;
    r.c = c; r.e = e; r.va = 32'(va); r.vb = 32'(vb);
    r.acc = 32'(ea); r.relu = 32'(er); r.vld = v;
    return r;
  endfunction

  task automatic run_table(input string name);
    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].e, vecs[i].va, vecs[i].vb);
      check($sformatf("%s[%0d].acc", name, i), acc, vecs[i].acc);
      check($sformatf("%s[%0d].relu", name, i), relu_acc, vecs[i].relu);
      check($sformatf("%s[%0d].valid", name, i), 32'(valid), 32'(vecs[i].vld));
    end
  endtask

  int conv_a[9] = '{1, 2, 3, 9, 10, 11, 17, 18, 19};
  int conv_b[9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  initial begin
    // reset state
    #12;
    check("reset.acc", acc, '0);
    check("reset.relu", relu_acc, '0);
    check("reset.valid", 32'(valid), '0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 3x3 convolution, positive result
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, -1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, -1, -1, 0, 1));
    vecs.push_back(mk(0, 1, 3, -1, -3, 0, 1));
    vecs.push_back(mk(0, 1, 9, 0, -6, 0, 1));
    vecs.push_back(mk(0, 1, 10, 0, -6, 0, 1));
    vecs.push_back(mk(0, 1, 11, 0, -6, 0, 1));
    vecs.push_back(mk(0, 1, 17, 1, -6, 0, 1));
    vecs.push_back(mk(0, 1, 18, 1, 11, 11, 1));
    vecs.push_back(mk(0, 1, 19, 1, 29, 29, 1));
    vecs.push_back(mk(0, 0, 0, 0, 48, 48, 1));
    vecs.push_back(mk(0, 0, 0, 0, 48, 48, 0));
    run_table("conv");

    // latency and gaps
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, 12, 1));
    vecs.push_back(mk(0, 0, 0, 0, 12, 12, 0));
    vecs.push_back(mk(0, 1, 2, 5, 12, 12, 0));
    vecs.push_back(mk(0, 0, 0, 0, 22, 22, 1));
    vecs.push_back(mk(0, 0, 0, 0, 22, 22, 0));
    run_table("gap");

    // negative result
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'(conv_a[i]), 32'(-conv_b[i]));
    idle();
    check("neg.acc", acc, 32'hFFFFFFD0);
    check("neg.relu", relu_acc, '0);

    // overflow of the DATA_W range
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'h7FFFFFFF, 32'd2);
    step(1'b0, 1'b1, 32'h7FFFFFFF, 32'd2);
    idle();
`ifdef MAC_SATURATE_EN
    check("ovf.acc", acc, 32'h7FFFFFFF);
`else
    check("ovf.acc", acc, 32'hFFFFFFFC);
`endif

    // clr wins over enable on the same edge
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'd6, 32'd8);
    idle();
    check("clrpri.pre", acc, 32'd48);
    step(1'b1, 1'b1, 32'd5, 32'd5);
    check("clrpri.acc0", acc, '0);
    check("clrpri.valid0", 32'(valid), '0);
    for (int i = 0; i < 2; i++) begin
      idle();
      check($sformatf("clrpri.acc%0d", i + 1), acc, '0);
      check($sformatf("clrpri.valid%0d", i + 1), 32'(valid), '0);
    end

    // asynchronous reset mid-cycle with a product in flight
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'd6, 32'd8);
    step(1'b0, 1'b1, 32'd1, 32'd1);
    check("arst.pre_acc", acc, 32'd48);
    check("arst.pre_valid", 32'(valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("arst.acc", acc, '0);
    check("arst.valid", 32'(valid), '0);
    check("arst.relu", relu_acc, '0);
    idle();
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("arst.post_acc%0d", i), acc, '0);
      check($sformatf("arst.post_valid%0d", i), 32'(valid), '0);
    end

    // randomized run against the model
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      bit rc, re;
      rc = ($urandom_range(0, 19) == 0);
      re = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        ra = $urandom();
        rb = $urandom();
      end else begin
        ra = 32'($signed(12'($urandom_range(0, 4095))));
        rb = 32'($signed(12'($urandom_range(0, 4095))));
      end
      step(rc, re, ra, rb);
      check_model($sformatf("rand[%0d]", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
